// File: rtl/msg_sequencer_if.sv
// Handshake and ROM bus of the message sequencer.
// The master side drives the controls and ROM data; the slave side is the sequencer.
interface msg_sequencer_if;
  logic       ena;
  logic [1:0] sel;
  logic       start;
  logic       stop;
  logic       loop;
  logic [3:0] rate;
  logic       ready;
  logic [7:0] rom_data;
  logic       rom_sel;
  logic [6:0] rom_addr;
  logic [7:0] char_out;
  logic       char_valid;
  logic       busy;
  logic       done;

  modport master (
    output ena, sel, start, stop, loop, rate, ready, rom_data,
    input  rom_sel, rom_addr, char_out, char_valid, busy, done
  );

  modport slave (
    input  ena, sel, start, stop, loop, rate, ready, rom_data,
    output rom_sel, rom_addr, char_out, char_valid, busy, done
  );
endinterface

// File: rtl/msg_sequencer.sv
// Streams one of two ROM-resident messages character by character to a ready/valid sink,
// with an optional inter-character gap, looping and abort.
module msg_sequencer #(
  parameter int MSG0_LAST = 58,
  parameter int MSG1_LAST = 76
) (
  input  logic            clk,
  input  logic            rst_n,
  msg_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LATCH,
    PRESENT,
    GAP
  } state_t;

  state_t     state_q, state_d;
  logic [6:0] addr_q, addr_d;
  logic       sel_q, sel_d;
  logic [7:0] char_q, char_d;
  logic       valid_q, valid_d;
  logic       done_q, done_d;
  logic [3:0] cnt_q, cnt_d;

  logic [6:0] last_idx;
  logic       at_last;

  assign last_idx = sel_q ? 7'(MSG1_LAST) : 7'(MSG0_LAST);
  assign at_last  = (addr_q >= last_idx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= 7'd0;
      sel_q   <= 1'b0;
      char_q  <= 8'h00;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      sel_q   <= sel_d;
      char_q  <= char_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    sel_d   = sel_q;
    char_d  = char_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    // done is a strobe: it drops on every edge, including disabled ones.
    done_d  = 1'b0;

    if (bus.ena) begin
      if (bus.stop) begin
        state_d = IDLE;
        valid_d = 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (bus.start) begin
              // 01/10 select message 1, 00/11 select message 0.
              sel_d   = ^bus.sel;
              addr_d  = 7'd0;
              state_d = FETCH;
            end
          end
          FETCH: begin
            state_d = LATCH;
          end
          LATCH: begin
            char_d  = bus.rom_data;
            valid_d = 1'b1;
            state_d = PRESENT;
          end
          PRESENT: begin
            if (bus.ready) begin
              valid_d = 1'b0;
              if (at_last && !bus.loop) begin
                done_d  = 1'b1;
                state_d = IDLE;
              end else begin
                addr_d = at_last ? 7'd0 : addr_q + 7'd1;
                if (bus.rate == 4'd0) begin
                  state_d = FETCH;
                end else begin
                  cnt_d   = bus.rate;
                  state_d = GAP;
                end
              end
            end
          end
          GAP: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) begin
              state_d = FETCH;
            end
          end
          default: begin
            state_d = IDLE;
          end
        endcase
      end
    end
  end

  assign bus.rom_sel    = sel_q;
  assign bus.rom_addr   = addr_q;
  assign bus.char_out   = char_q;
  assign bus.char_valid = valid_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = done_q;

endmodule
